// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings for the scoreboard-based hazard unit: stall causes and
// producer latency constants.
package hazard_scoreboard_pkg;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    CAUSE_DATA = 2'b01,
    CAUSE_BR   = 2'b10,
    CAUSE_MDU  = 2'b11
  } stall_cause_e;

  localparam int LAT_ALU  = 0;
  localparam int LAT_LOAD = 1;

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard countdown: loads a saturated (latency + BR_EXTRA) on issue,
// otherwise counts down to zero and holds there.
module hazard_sb_entry #(
  parameter int LAT_W    = 3,
  parameter int BR_EXTRA = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LAT_W-1:0] lat,
  output logic [LAT_W-1:0] cnt
);

  localparam logic [LAT_W:0] EXTRA   = (LAT_W+1)'(BR_EXTRA);
  localparam logic [LAT_W:0] CNT_MAX = {1'b0, {LAT_W{1'b1}}};

  logic [LAT_W:0]   sum;
  logic [LAT_W-1:0] load_val;

  // Extra carry bit lets a long latency clamp to all-ones instead of wrapping.
  assign sum      = {1'b0, lat} + EXTRA;
  assign load_val = (sum > CNT_MAX) ? {LAT_W{1'b1}} : sum[LAT_W-1:0];

  // NOTE: sequential state is assigned with <= so every entry samples the
  // pre-edge values; a new load wins over the decrement of the same entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - LAT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: per-register countdown scoreboard of in-flight writes,
// data/branch/MDU stall detection, pipeline enables and a saturating stall counter.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int NUM_REGS = 32,
  parameter int LAT_W    = 3,
  parameter int BR_EXTRA = 1,
  parameter int SCNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_is_branch,
  input  logic              id_wr_en,
  input  logic [REG_AW-1:0] id_wr_reg,
  input  logic [LAT_W-1:0]  id_wr_lat,
  input  logic              id_need_mdu,
  input  logic              mdu_busy,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ctrl_set_zero,
  output logic [1:0]        stall_cause,
  output logic [SCNT_W-1:0] stall_cnt
);

  localparam logic [LAT_W:0] EXTRA = (LAT_W+1)'(BR_EXTRA);

  logic [LAT_W-1:0] cnt [NUM_REGS];
  logic [LAT_W-1:0] rs_cnt, rt_cnt;
  logic             rs_haz, rt_haz, mdu_haz, reg_haz, stall, issue;
  stall_cause_e     cause;

  assign cnt[0] = '0;

  // NOTE: scoreboard entries live in flops with async reset (not a RAM), so a
  // mid-stall reset clears every pending write at once.
  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    hazard_sb_entry #(
      .LAT_W   (LAT_W),
      .BR_EXTRA(BR_EXTRA)
    ) u_entry (
      .clk (clk),
      .rst (rst),
      .load(issue && id_wr_en && (id_wr_reg == REG_AW'(r))),
      .lat (id_wr_lat),
      .cnt (cnt[r])
    );
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    rs_cnt = '0;
    rt_cnt = '0;
    if (int'(id_rs) < NUM_REGS) rs_cnt = cnt[id_rs];
    if (int'(id_rt) < NUM_REGS) rt_cnt = cnt[id_rt];
  end

  // Branches consume operands one stage earlier, so any pending count stalls them.
  assign rs_haz = id_use_rs && (id_rs != '0) &&
                  (id_is_branch ? (rs_cnt != '0) : ({1'b0, rs_cnt} > EXTRA));
  assign rt_haz = id_use_rt && (id_rt != '0) &&
                  (id_is_branch ? (rt_cnt != '0) : ({1'b0, rt_cnt} > EXTRA));
  assign mdu_haz = id_need_mdu && mdu_busy;
  assign reg_haz = rs_haz || rt_haz;

  assign stall = id_valid && (mdu_haz || reg_haz);
  assign issue = id_valid && !stall;

  always_comb begin
    cause = CAUSE_NONE;
    if (id_valid) begin
      if (mdu_haz)                       cause = CAUSE_MDU;
      else if (reg_haz && id_is_branch)  cause = CAUSE_BR;
      else if (reg_haz)                  cause = CAUSE_DATA;
    end
  end

  assign stall_cause   = cause;
  assign pc_write      = !stall;
  assign ifid_write    = !stall;
  assign ctrl_set_zero = stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + SCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench: stimulus queues expected outputs per cycle; a
// negedge monitor pops and compares against the DUT.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_wr_reg = '0;
  logic        id_use_rs = 1'b0, id_use_rt = 1'b0, id_is_branch = 1'b0;
  logic        id_wr_en = 1'b0, id_need_mdu = 1'b0, mdu_busy = 1'b0;
  logic [2:0]  id_wr_lat = '0;
  logic        pc_write, ifid_write, ctrl_set_zero;
  logic [1:0]  stall_cause;
  logic [15:0] stall_cnt;

  typedef struct {
    logic        stall;
    logic [1:0]  cause;
    logic [15:0] scnt;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] model_scnt = '0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_is_branch (id_is_branch),
    .id_wr_en     (id_wr_en),
    .id_wr_reg    (id_wr_reg),
    .id_wr_lat    (id_wr_lat),
    .id_need_mdu  (id_need_mdu),
    .mdu_busy     (mdu_busy),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ctrl_set_zero(ctrl_set_zero),
    .stall_cause  (stall_cause),
    .stall_cnt    (stall_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One ID-stage cycle: drive after the rising edge, queue what the DUT must show.
  task automatic step(input string name, input logic v,
                      input logic [4:0] rs, input logic urs,
                      input logic [4:0] rt, input logic urt,
                      input logic br, input logic wen, input logic [4:0] wr,
                      input logic [2:0] lat, input logic mdu, input logic busy,
                      input logic rst_val, input logic e_stall, input logic [1:0] e_cause);
    exp_t e;
    @(posedge clk);
    #1;
    rst          = rst_val;
    id_valid     = v;
    id_rs        = rs;
    id_use_rs    = urs;
    id_rt        = rt;
    id_use_rt    = urt;
    id_is_branch = br;
    id_wr_en     = wen;
    id_wr_reg    = wr;
    id_wr_lat    = lat;
    id_need_mdu  = mdu;
    mdu_busy     = busy;
    if (rst_val) model_scnt = '0;
    e.stall = e_stall;
    e.cause = e_cause;
    e.scnt  = model_scnt;
    e.name  = name;
    exp_q.push_back(e);
    if (e_stall && !rst_val && model_scnt != 16'hffff) model_scnt++;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check({mon_e.name, ".pc_write"},      32'(pc_write),      32'(!mon_e.stall));
      check({mon_e.name, ".ifid_write"},    32'(ifid_write),    32'(!mon_e.stall));
      check({mon_e.name, ".ctrl_set_zero"}, 32'(ctrl_set_zero), 32'(mon_e.stall));
      check({mon_e.name, ".stall_cause"},   32'(stall_cause),   32'(mon_e.cause));
      check({mon_e.name, ".stall_cnt"},     32'(stall_cnt),     32'(mon_e.scnt));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    //    name        v  rs    urs rt    urt br wen wr    lat  mdu busy rst stall cause
    step("reset",     0, 5'd0, 0, 5'd0, 0,  0, 0, 5'd0, 3'd0, 0, 0, 1, 0, 2'b00);
    // load-use
    step("lw8",       1, 5'd1, 1, 5'd0, 0,  0, 1, 5'd8, 3'd1, 0, 0, 0, 0, 2'b00);
    step("lu_stall",  1, 5'd8, 1, 5'd0, 0,  0, 1, 5'd10,3'd0, 0, 0, 0, 1, 2'b01);
    step("lu_issue",  1, 5'd8, 1, 5'd0, 0,  0, 1, 5'd10,3'd0, 0, 0, 0, 0, 2'b00);
    step("idle1",     0, 5'd0, 0, 5'd0, 0,  0, 0, 5'd0, 3'd0, 0, 0, 0, 0, 2'b00);
    // ALU -> beq
    step("add9",      1, 5'd1, 1, 5'd2, 1,  0, 1, 5'd9, 3'd0, 0, 0, 0, 0, 2'b00);
    step("ab_stall",  1, 5'd9, 1, 5'd0, 0,  1, 0, 5'd0, 3'd0, 0, 0, 0, 1, 2'b10);
    step("ab_issue",  1, 5'd9, 1, 5'd0, 0,  1, 0, 5'd0, 3'd0, 0, 0, 0, 0, 2'b00);
    // load -> beq
    step("lw9",       1, 5'd1, 1, 5'd0, 0,  0, 1, 5'd9, 3'd1, 0, 0, 0, 0, 2'b00);
    step("lb_stall1", 1, 5'd0, 0, 5'd9, 1,  1, 0, 5'd0, 3'd0, 0, 0, 0, 1, 2'b10);
    step("lb_stall2", 1, 5'd0, 0, 5'd9, 1,  1, 0, 5'd0, 3'd0, 0, 0, 0, 1, 2'b10);
    step("lb_issue",  1, 5'd0, 0, 5'd9, 1,  1, 0, 5'd0, 3'd0, 0, 0, 0, 0, 2'b00);
    // register 0 and unused operand
    step("lw0",       1, 5'd1, 1, 5'd0, 0,  0, 1, 5'd0, 3'd1, 0, 0, 0, 0, 2'b00);
    step("use0",      1, 5'd0, 1, 5'd0, 1,  0, 0, 5'd0, 3'd0, 0, 0, 0, 0, 2'b00);
    step("lw5",       1, 5'd1, 1, 5'd0, 0,  0, 1, 5'd5, 3'd1, 0, 0, 0, 0, 2'b00);
    step("unused_rt", 1, 5'd1, 1, 5'd5, 0,  0, 0, 5'd0, 3'd0, 0, 0, 0, 0, 2'b00);
    // overwrite with saturating latency: 7 -> stalls at 7,6,5,4,3,2
    step("lw3",       1, 5'd1, 1, 5'd0, 0,  0, 1, 5'd3, 3'd1, 0, 0, 0, 0, 2'b00);
    step("ovr3",      1, 5'd4, 1, 5'd0, 0,  0, 1, 5'd3, 3'd7, 0, 0, 0, 0, 2'b00);
    for (int i = 0; i < 6; i++)
      step($sformatf("sat_stall%0d", i), 1, 5'd3, 1, 5'd0, 0, 0, 0, 5'd0, 3'd0, 0, 0, 0, 1, 2'b01);
    step("sat_issue", 1, 5'd3, 1, 5'd0, 0,  0, 0, 5'd0, 3'd0, 0, 0, 0, 0, 2'b00);
    // MDU priority over a pending lat-3 producer (cnt 4)
    step("ld12",      1, 5'd1, 1, 5'd0, 0,  0, 1, 5'd12,3'd3, 0, 0, 0, 0, 2'b00);
    step("mdu_pri",   1, 5'd12,1, 5'd0, 0,  0, 1, 5'd13,3'd2, 1, 1, 0, 1, 2'b11);
    step("mdu_data1", 1, 5'd12,1, 5'd0, 0,  0, 1, 5'd13,3'd2, 1, 0, 0, 1, 2'b01);
    step("mdu_data2", 1, 5'd12,1, 5'd0, 0,  0, 1, 5'd13,3'd2, 1, 0, 0, 1, 2'b01);
    step("mdu_issue", 1, 5'd12,1, 5'd0, 0,  0, 1, 5'd13,3'd2, 1, 0, 0, 0, 2'b00);
    step("mdu_only",  1, 5'd0, 1, 5'd0, 1,  0, 0, 5'd0, 3'd0, 1, 1, 0, 1, 2'b11);
    step("mdu_free",  1, 5'd0, 1, 5'd0, 1,  0, 0, 5'd0, 3'd0, 1, 0, 0, 0, 2'b00);
    // reset during a data stall on a lat-3 producer (cnt 4)
    step("ld8",       1, 5'd1, 1, 5'd0, 0,  0, 1, 5'd8, 3'd3, 0, 0, 0, 0, 2'b00);
    step("rs_stall",  1, 5'd8, 1, 5'd0, 0,  0, 0, 5'd0, 3'd0, 0, 0, 0, 1, 2'b01);
    step("rs_reset",  1, 5'd8, 1, 5'd0, 0,  0, 0, 5'd0, 3'd0, 0, 0, 1, 0, 2'b00);
    step("rs_issue",  1, 5'd8, 1, 5'd0, 0,  0, 0, 5'd0, 3'd0, 0, 0, 0, 0, 2'b00);
    step("idle_end",  0, 5'd0, 0, 5'd0, 0,  0, 0, 5'd0, 3'd0, 0, 0, 0, 0, 2'b00);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the combinational load-use/branch hazard checker.
- Keeps a per-register countdown scoreboard of in-flight writes instead of comparing fixed ID/EX and EX/MEM fields, so any producer latency works (ALU, load, multi-cycle MDU).
- Sits beside the ID stage. Drives PC/IF-ID write enables and the control-zeroing bubble. Keeps a saturating stall counter for performance monitoring.

Parameters:
- REG_AW, 5, register address width
- NUM_REGS, 32, architectural register count (at most 2**REG_AW); register 0 is never tracked
- LAT_W, 3, width of each countdown entry; maximum stored value is 2**LAT_W-1
- BR_EXTRA, 1, extra cycles a branch resolved in ID needs beyond an EX-stage consumer
- SCNT_W, 16, stall counter width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- id_valid  in  1  valid instruction in IF/ID
- id_rs  in  REG_AW  source register rs
- id_rt  in  REG_AW  source register rt
- id_use_rs  in  1  instruction reads rs
- id_use_rt  in  1  instruction reads rt
- id_is_branch  in  1  operands are consumed in ID (beq/bne)
- id_wr_en  in  1  instruction writes a register
- id_wr_reg  in  REG_AW  destination register
- id_wr_lat  in  LAT_W  producer latency: 0 = ALU (EX forward), 1 = load, N = multi-cycle
- id_need_mdu  in  1  instruction uses the multiply/divide unit
- mdu_busy  in  1  MDU currently occupied
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID register write enable
- ctrl_set_zero  out  1  insert bubble into ID/EX
- stall_cause  out  2  00 none, 01 data, 10 branch-data, 11 MDU busy
- stall_cnt  out  SCNT_W  cycles stalled since reset, saturating

Behaviour:
- Reset (asynchronous, rst=1):
  - all scoreboard entries = 0 and stall_cnt = 0
  - outputs pc_write=1, ifid_write=1, ctrl_set_zero=0, stall_cause=00 (follow from zero state)
- Scoreboard: cnt[r] for r = 1..NUM_REGS-1. cnt[0] is hard-wired 0.
- Hazard checks (combinational from current cnt and ID inputs). Only a source with its use flag set and address nonzero is checked.
  - Data hazard for a non-branch consumer: cnt[src] > BR_EXTRA.
  - Data hazard for a branch consumer: cnt[src] != 0.
  - MDU hazard: id_need_mdu && mdu_busy.
- stall = id_valid && (any hazard). When stall=1: pc_write=0, ifid_write=0, ctrl_set_zero=1. Otherwise the inverse values.
- stall_cause priority: MDU (11) > branch-data (10) > data (01) > none (00).
- Issue: issue = id_valid && !stall. On the clock edge with issue && id_wr_en && id_wr_reg != 0:
  - cnt[id_wr_reg] <= min(id_wr_lat + BR_EXTRA, 2**LAT_W-1)
  - compute with one extra bit, then saturate.
- Decrement: every other nonzero entry decrements by 1 each cycle. Zero entries hold.
- Simultaneous events:
  - an issue write to reg X overrides the decrement of X in the same cycle
  - a stalled instruction never writes the scoreboard
  - the bubble carries no write
- Resulting stall latencies with BR_EXTRA=1:
  - ALU→ALU: 0 cycles
  - load→ALU: 1 cycle
  - ALU→beq: 1 cycle
  - load→beq: 2 cycles
  - MDU result with lat N → ALU: N cycles
- stall_cnt increments on each cycle with stall=1 and saturates at all-ones.
- Reset asserted mid-stall clears all pending entries immediately. The next cycle after deassertion issues freely.
- Latency: stall outputs are combinational in the same cycle. Scoreboard updates take effect the cycle after issue.

Decomposition:
- Shared package:
  - stall-cause encodings (CAUSE_NONE, CAUSE_DATA, CAUSE_BR, CAUSE_MDU)
  - latency constants LAT_ALU=0, LAT_LOAD=1
- Sub-module: hazard_sb_entry, one countdown register with load/decrement/saturate.
  - Instantiated NUM_REGS-1 times via generate.
  - Top level holds the read muxes, the hazard compare, the cause encoder and stall_cnt.

Test Plan:
- Load-use: issue lw $8 (lat 1), next cycle add rs=$8 → exactly 1 cycle ctrl_set_zero=1, stall_cause=01; add issues on cycle 2; stall_cnt=1.
- Branch after ALU/load:
  - add $9 (lat 0) then beq rs=$9 → 1 stall, cause=10.
  - lw $9 then beq rt=$9 → 2 stalls, cause=10.
- Register 0 and unused operands:
  - lw $0 then add rs=$0 → no stall.
  - lw $5 then instruction with id_use_rt=0, rt=$5 → no stall.
- Overwrite and saturation: lw $3 (cnt=2), next cycle independent instruction issues with write to $3 lat 7 → cnt[$3]=7 (saturated, overrides the decrement); dependent ALU stalls 6 cycles.
- MDU priority: mdu_busy=1 and id_need_mdu=1 while also data-dependent on a pending load → stall_cause=11; drop mdu_busy → cause falls to 01 until cnt ≤ 1.
- Reset mid-stall: assert rst during a load-use stall → pc_write=1, ctrl_set_zero=0, stall_cnt=0 immediately; dependent instruction issues in the first cycle after release.
